// File: rtl/mor1kx_bp_pkg.sv
// Shared definitions for the mor1kx branch predictors: counter encodings,
// PHT controller FSM states and the saturating counter update.
package mor1kx_bp_pkg;

  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pht_state_t;

  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    if (taken)
      return (cnt == CNT_STRONG_T) ? CNT_STRONG_T : cnt + 2'd1;
    else
      return (cnt == CNT_STRONG_NT) ? CNT_STRONG_NT : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/mor1kx_bp_pht_ram.sv
// Single-port PHT storage: synchronous read, a write wins the port, no reset.
// Read data holds its value until the next read.
module mor1kx_bp_pht_ram #(
  parameter int IDX_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [IDX_WIDTH-1:0] addr,
  input  logic [1:0]           wdata,
  output logic [1:0]           rdata
);

  localparam int DEPTH = 1 << IDX_WIDTH;

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/mor1kx_branch_predictor_pht_ctrl.sv
// PHT controller: arbitrates the single table port between the init sweep,
// buffered resolution updates and decode lookups. Optional gshare indexing
// is enabled with MOR1KX_BRANCH_PREDICTOR_GSHARE_EN.
module mor1kx_branch_predictor_pht_ctrl
  import mor1kx_bp_pkg::*;
#(
  parameter int IDX_WIDTH            = 6,
  parameter int OPTION_OPERAND_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush_i,
  input  logic                            lookup_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lookup_pc_i,
  input  logic                            op_bf_i,
  input  logic                            op_bnf_i,
  output logic                            lookup_stall_o,
  output logic                            predicted_valid_o,
  output logic                            predicted_flag_o,
  output logic [1:0]                      predicted_cnt_o,
  output logic [IDX_WIDTH-1:0]            predicted_idx_o,
  input  logic                            update_req_i,
  input  logic [IDX_WIDTH-1:0]            update_idx_i,
  input  logic [1:0]                      update_cnt_i,
  input  logic                            update_taken_i,
  output logic                            busy_o
);

  // Handshake: a lookup transfers in any cycle with lookup_req_i=1 and
  // lookup_stall_o=0; its result is presented one cycle later with
  // predicted_valid_o=1. Updates are always accepted in RUN, dropped in INIT.

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;

  pht_state_t           state, state_next;
  logic [IDX_WIDTH-1:0] init_idx;
  logic                 pend_valid;
  logic [IDX_WIDTH-1:0] pend_idx;
  logic [1:0]           pend_cnt;
  logic [IDX_WIDTH-1:0] lookup_idx;
  logic                 drain, grant;
  logic                 ram_we, ram_re;
  logic [IDX_WIDTH-1:0] ram_addr;
  logic [1:0]           ram_wdata, ram_rdata;
  logic                 fwd_hit_q;
  logic [1:0]           fwd_cnt_q;
  logic                 op_bf_q, op_bnf_q;
  logic                 unused_pc;

  assign unused_pc = ^{lookup_pc_i[OPTION_OPERAND_WIDTH-1:IDX_WIDTH+2], lookup_pc_i[1:0]};

`ifdef MOR1KX_BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX_WIDTH-1:0] ghr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ghr <= '0;
    else if (flush_i)
      ghr <= '0;
    else if (state == ST_RUN && update_req_i)
      ghr <= {ghr[IDX_WIDTH-2:0], update_taken_i};
  end

  assign lookup_idx = lookup_pc_i[IDX_WIDTH+1:2] ^ ghr;
`else
  assign lookup_idx = lookup_pc_i[IDX_WIDTH+1:2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_INIT;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (flush_i)
      state_next = ST_INIT;
    else if (state == ST_INIT && init_idx == LAST_IDX)
      state_next = ST_RUN;
  end

  // Draining whenever an update arrives keeps the one-entry buffer from overflowing.
  always_comb begin
    drain          = (state == ST_RUN) && pend_valid && (!lookup_req_i || update_req_i);
    grant          = (state == ST_RUN) && lookup_req_i && !drain;
    lookup_stall_o = lookup_req_i && !grant;
    busy_o         = (state == ST_INIT);
    ram_we         = (state == ST_INIT) || drain;
    ram_re         = grant;
    ram_addr       = lookup_idx;
    ram_wdata      = pend_cnt;
    if (state == ST_INIT) begin
      ram_addr  = init_idx;
      ram_wdata = CNT_WEAK_T;
    end else if (drain) begin
      ram_addr  = pend_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      init_idx <= '0;
    else if (flush_i)
      init_idx <= '0;
    else if (state == ST_INIT)
      init_idx <= init_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_cnt   <= CNT_STRONG_NT;
    end else if (flush_i || state == ST_INIT) begin
      pend_valid <= 1'b0;
    end else if (update_req_i) begin
      pend_valid <= 1'b1;
      pend_idx   <= update_idx_i;
      pend_cnt   <= cnt_next(update_cnt_i, update_taken_i);
    end else if (drain) begin
      pend_valid <= 1'b0;
    end
  end

  // The forward flag starts set so the reset counter value comes from a register, not the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      predicted_valid_o <= 1'b0;
      predicted_idx_o   <= '0;
      op_bf_q           <= 1'b0;
      op_bnf_q          <= 1'b0;
      fwd_hit_q         <= 1'b1;
      fwd_cnt_q         <= CNT_WEAK_T;
    end else begin
      predicted_valid_o <= grant;
      if (grant) begin
        predicted_idx_o <= lookup_idx;
        op_bf_q         <= op_bf_i;
        op_bnf_q        <= op_bnf_i;
        fwd_hit_q       <= pend_valid && (pend_idx == lookup_idx);
        fwd_cnt_q       <= pend_cnt;
      end
    end
  end

  assign predicted_cnt_o  = fwd_hit_q ? fwd_cnt_q : ram_rdata;
  assign predicted_flag_o = (predicted_cnt_o[1] && op_bf_q) || (!predicted_cnt_o[1] && op_bnf_q);

  mor1kx_bp_pht_ram #(
    .IDX_WIDTH(IDX_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule
